// File: rtl/neuron_mac_seq_pkg.sv
// neuron_mac_seq_pkg: FSM states and Q8.8 constants shared by the neuron MAC
package neuron_mac_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, BIAS, OUT} state_t;
    localparam int FRAC_W = 8;
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;
    localparam int N_INPUTS_DEF = 28;
endpackage

// File: rtl/neuron_mac_seq_if.sv
// neuron_mac_seq_if: start/bias, activation stream, weight BRAM port and result handshake
interface neuron_mac_seq_if #(parameter int DATA_W = 16);
    logic              START;
    logic [DATA_W-1:0] BIAS;
    logic              BUSY;
    logic [DATA_W-1:0] X_DATA;
    logic              X_VALID;
    logic              X_READY;
    logic [4:0]        W_ADDR;
    logic              W_EN;
    logic              W_WE;
    logic [DATA_W-1:0] W_DI;
    logic [DATA_W-1:0] W_DO;
    logic [DATA_W-1:0] Y_DATA;
    logic              Y_VALID;
    logic              Y_READY;
    modport master (
        output START, BIAS, X_DATA, X_VALID, W_DO, Y_READY,
        input  BUSY, X_READY, W_ADDR, W_EN, W_WE, W_DI, Y_DATA, Y_VALID
    );
    modport slave (
        input  START, BIAS, X_DATA, X_VALID, W_DO, Y_READY,
        output BUSY, X_READY, W_ADDR, W_EN, W_WE, W_DI, Y_DATA, Y_VALID
    );
endinterface

// File: rtl/neuron_requant.sv
// neuron_requant: acc >>> FRAC_W, saturate to Q8.8, optional ReLU under NEURON_RELU_EN
module neuron_requant
    import neuron_mac_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [DATA_W-1:0] y
);
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] sat;
    always_comb begin
        shifted = acc >>> FRAC_W;
        sat = shifted > ACC_W'(SAT_MAX) ? ACC_W'(SAT_MAX) :
              shifted < ACC_W'(SAT_MIN) ? ACC_W'(SAT_MIN) : shifted;
`ifdef NEURON_RELU_EN
        y = sat[ACC_W-1] ? '0 : sat[DATA_W-1:0];
`else
        y = sat[DATA_W-1:0];
`endif
    end
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential Q8.8 neuron, one weight*activation MAC per cycle, then bias and requantise
module neuron_mac_seq
    import neuron_mac_seq_pkg::*;
#(
    parameter int N_INPUTS = N_INPUTS_DEF,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40
) (
    input logic             CLK,
    input logic             RST_N,
    neuron_mac_seq_if.slave bus
);
    state_t state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_bias;
    logic [4:0] addr_q, addr_d;
    logic [DATA_W-1:0] bias_q, bias_d, y_q, y_d, y_req;
    logic signed [2*DATA_W-1:0] prod;
    logic start_ok, accept, last;

    always_ff @(posedge CLK)
        if (!RST_N) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = bus.START ? RUN : IDLE;
            RUN:  state_d = accept && last ? BIAS : RUN;
            BIAS: state_d = OUT;
            OUT:  state_d = bus.Y_READY ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.W_EN    = state_q == RUN;
        bus.X_READY = state_q == RUN;
        bus.BUSY    = state_q != IDLE;
        bus.Y_VALID = state_q == OUT;
        bus.W_ADDR  = addr_q;
        bus.W_WE    = 1'b0;
        bus.W_DI    = '0;
        bus.Y_DATA  = y_q;
    end

    // W_DO already holds the weight for addr_q: the BRAM reads it on the preceding negedge
    always_comb begin
        start_ok = state_q == IDLE && bus.START;
        accept   = state_q == RUN && bus.X_VALID;
        last     = addr_q == 5'(N_INPUTS - 1);
        prod     = $signed(bus.X_DATA) * $signed(bus.W_DO);
        acc_bias = acc_q + (ACC_W'($signed(bias_q)) <<< FRAC_W);
        acc_d    = start_ok ? '0 : accept ? acc_q + ACC_W'(prod) : state_q == BIAS ? acc_bias : acc_q;
        addr_d   = start_ok ? '0 : accept && !last ? addr_q + 5'd1 : addr_q;
        bias_d   = start_ok ? bus.BIAS : bias_q;
        y_d      = state_q == BIAS ? y_req : y_q;
    end

    neuron_requant #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_requant (.acc(acc_bias), .y(y_req));

    always_ff @(posedge CLK)
        if (!RST_N) begin
            acc_q  <= '0;
            addr_q <= '0;
            bias_q <= '0;
            y_q    <= '0;
        end else begin
            acc_q  <= acc_d;
            addr_q <= addr_d;
            bias_q <= bias_d;
            y_q    <= y_d;
        end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: randomized bench against an arithmetic neuron model, honours NEURON_RELU_EN
module tb_neuron_mac_seq;
    localparam int N = 28;
    logic CLK = 1'b0;
    logic RST_N;
    int n_tests = 0;
    int n_fail = 0;
    logic [15:0] xs [32];
    logic [15:0] wm [32];
    logic [15:0] y;

    neuron_mac_seq_if #(.DATA_W(16)) bus ();
    neuron_mac_seq #(.N_INPUTS(N), .DATA_W(16), .ACC_W(40)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    always #5 CLK = ~CLK;

    always @(negedge CLK)
        if (bus.W_EN) bus.W_DO <= wm[bus.W_ADDR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] b);
        longint a = 0;
        for (int i = 0; i < N; i++) a += longint'($signed(xs[i])) * longint'($signed(wm[i]));
        a += longint'($signed(b)) * 256;
        a = a >>> 8;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
`ifdef NEURON_RELU_EN
        if (a < 0) a = 0;
`endif
        return a[15:0];
    endfunction

    task automatic fill(input logic [15:0] x, input logic [15:0] w);
        for (int i = 0; i < 32; i++) begin
            xs[i] = x;
            wm[i] = w;
        end
    endtask

    task automatic run_neuron(input logic [15:0] b, input int duty, input int hold, output logic [15:0] yo);
        int cyc;
        int idx;
        logic v;
        logic [15:0] exp;
        exp = model(b);
        bus.BIAS = b;
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.BIAS = 16'($urandom);
        cyc = 1;
        idx = 0;
        check("busy", bus.BUSY, 1);
        check("x_ready", bus.X_READY, 1);
        while (idx < N && cyc < 1000) begin
            v = $urandom_range(0, 99) < duty;
            bus.X_VALID = v;
            bus.X_DATA = v ? xs[idx] : 16'($urandom);
            if (v) check("w_addr", bus.W_ADDR, idx);
            @(negedge CLK);
            cyc++;
            if (v) idx++;
        end
        bus.X_VALID = 1'b0;
        while (!bus.Y_VALID && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
        end
        if (duty >= 100) check("latency", cyc, N + 2);
        check("y_valid", bus.Y_VALID, 1);
        check("y_data", bus.Y_DATA, exp);
        yo = bus.Y_DATA;
        for (int i = 0; i < hold; i++) begin
            bus.START = 1'b1;
            bus.BIAS = 16'($urandom);
            @(negedge CLK);
            check("hold_data", bus.Y_DATA, exp);
            check("hold_valid", bus.Y_VALID, 1);
            check("hold_xready", bus.X_READY, 0);
        end
        bus.START = 1'b0;
        bus.Y_READY = 1'b1;
        @(negedge CLK);
        bus.Y_READY = 1'b0;
        check("handoff_valid", bus.Y_VALID, 0);
        check("handoff_busy", bus.BUSY, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.BUSY, 0);
        check({tag, "_xready"}, bus.X_READY, 0);
        check({tag, "_wen"}, bus.W_EN, 0);
        check({tag, "_waddr"}, bus.W_ADDR, 0);
        check({tag, "_yvalid"}, bus.Y_VALID, 0);
        check({tag, "_ydata"}, bus.Y_DATA, 0);
        check({tag, "_wwe"}, bus.W_WE, 0);
        check({tag, "_wdi"}, bus.W_DI, 0);
    endtask

    initial begin
        RST_N = 1'b0;
        bus.START = 1'b0;
        bus.BIAS = '0;
        bus.X_DATA = '0;
        bus.X_VALID = 1'b0;
        bus.Y_READY = 1'b0;
        fill(16'h0, 16'h0);
        repeat (2) @(negedge CLK);
        check_reset_outputs("por");
        RST_N = 1'b1;
        @(negedge CLK);

        fill(16'h0080, 16'h0100);
        run_neuron(16'h0100, 100, 0, y);
        check("basic_const", y, 16'h0F00);

        fill(16'h7FFF, 16'h7FFF);
        run_neuron(16'h7FFF, 100, 0, y);
        check("sat_const", y, 16'h7FFF);

        fill(16'h0100, 16'hFF00);
        run_neuron(16'h0000, 100, 0, y);
`ifdef NEURON_RELU_EN
        check("neg_const", y, 16'h0000);
`else
        check("neg_const", y, 16'hE400);
`endif

        fill(16'h0080, 16'h0100);
        run_neuron(16'h0100, 50, 0, y);
        check("stall_const", y, 16'h0F00);

        run_neuron(16'h0100, 100, 5, y);
        check("hold_const", y, 16'h0F00);

        bus.BIAS = 16'h0100;
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.X_VALID = 1'b1;
            bus.X_DATA = xs[i];
            @(negedge CLK);
        end
        check("mid_waddr", bus.W_ADDR, 10);
        bus.X_VALID = 1'b0;
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check_reset_outputs("midrst");
        run_neuron(16'h0100, 100, 0, y);
        check("after_rst_const", y, 16'h0F00);

        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 32; i++) begin
                xs[i] = 16'($urandom_range(0, 1023) - 512);
                wm[i] = 16'($urandom_range(0, 1023) - 512);
            end
            run_neuron(16'($urandom), $urandom_range(30, 100), $urandom_range(0, 3), y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
